// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer / VRAM arbitration path.
// 160x120 framebuffer of 3-bit RGB; each framebuffer pixel covers a 4x4 screen block.
package vga_pkg;

    localparam int FB_W        = 160;
    localparam int FB_H        = 120;
    localparam int SCALE_SHIFT = 2;
    localparam int ADDR_W      = 15;
    localparam int RGB_W       = 3;
    localparam int X_W         = 8;
    localparam int Y_W         = 7;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [RGB_W-1:0] rgb;
    } wr_entry_t;

    localparam int WR_ENTRY_W = $bits(wr_entry_t);

    // y*160 + x built from shifts so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] y_ext;
        logic [ADDR_W-1:0] x_ext;
        y_ext = {{(ADDR_W-Y_W){1'b0}}, y};
        x_ext = {{(ADDR_W-X_W){1'b0}}, x};
        return (y_ext << 7) + (y_ext << 5) + x_ext;
    endfunction

    function automatic logic in_range(input wr_entry_t e);
        return (e.x < X_W'(FB_W)) && (e.y < Y_W'(FB_H));
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Small first-word-fall-through FIFO holding pending pixel writes.
// Head is visible combinationally; push and pop in one cycle leave the count unchanged.
module vram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Storage carries no reset: pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares single-port VRAM between display fetch (absolute priority) and queued pixel writes.
// Define VRAM_ARB_BLANK_ONLY_EN to restrict write slots to blanking (vid_active = 0).
module vga_vram_arbiter
    import vga_pkg::*;
#(
    parameter int WR_FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vid_active,
    input  logic [9:0]        vid_x,
    input  logic [8:0]        vid_y,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [X_W-1:0]    wr_x,
    input  logic [Y_W-1:0]    wr_y,
    input  logic [RGB_W-1:0]  wr_rgb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [RGB_W-1:0]  mem_wdata,
    input  logic [RGB_W-1:0]  mem_rdata,
    output logic [RGB_W-1:0]  oRGB
);

    wr_entry_t               wr_entry;
    wr_entry_t               head;
    logic [WR_ENTRY_W-1:0]   head_bits;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    display_slot;
    logic                    write_slot;
    logic                    grant_write;
    logic [ADDR_W-1:0]       disp_addr;
    logic [ADDR_W-1:0]       head_addr;
    logic [ADDR_W-1:0]       addr_hold_reg;
    logic [RGB_W-1:0]        wdata_hold_reg;
    logic [RGB_W-1:0]        pix_reg;
    logic                    disp_d1_reg;
    logic                    active_d1;
    logic                    active_d2;

    assign wr_entry = '{x: wr_x, y: wr_y, rgb: wr_rgb};
    assign head     = wr_entry_t'(head_bits);

    // wr_ready is gated by reset so no request is accepted while reset is held.
    assign wr_ready = reset && !fifo_full;
    assign push     = wr_valid && wr_ready;

    vram_wr_fifo #(
        .DEPTH (WR_FIFO_DEPTH),
        .WIDTH (WR_ENTRY_W)
    ) u_wr_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (wr_entry),
        .pop       (write_slot),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign display_slot = vid_active && (vid_x[1:0] == 2'b00);
    assign disp_addr    = fb_addr(X_W'(vid_x >> SCALE_SHIFT), Y_W'(vid_y >> SCALE_SHIFT));
    assign head_addr    = fb_addr(head.x, head.y);

`ifdef VRAM_ARB_BLANK_ONLY_EN
    assign write_slot = !vid_active && !fifo_empty;
`else
    assign write_slot = !display_slot && !fifo_empty;
`endif

    // Out-of-range heads still consume their slot but never reach the RAM.
    assign grant_write = write_slot && in_range(head);

    always_comb begin
        mem_addr  = addr_hold_reg;
        mem_we    = 1'b0;
        mem_wdata = wdata_hold_reg;
        if (!reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (display_slot) begin
            mem_addr = disp_addr;
        end else if (grant_write) begin
            mem_addr  = head_addr;
            mem_we    = 1'b1;
            mem_wdata = head.rgb;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
            disp_d1_reg    <= 1'b0;
            pix_reg        <= '0;
            active_d1      <= 1'b0;
            active_d2      <= 1'b0;
        end else begin
            if (display_slot) begin
                addr_hold_reg <= disp_addr;
            end else if (grant_write) begin
                addr_hold_reg  <= head_addr;
                wdata_hold_reg <= head.rgb;
            end
            disp_d1_reg <= display_slot;
            // RAM data for a display slot is valid one cycle after its address.
            if (disp_d1_reg) begin
                pix_reg <= mem_rdata;
            end
            active_d1 <= vid_active;
            active_d2 <= active_d1;
        end
    end

    assign oRGB = active_d2 ? pix_reg : '0;

endmodule

// File: doc/vga_vram_arbiter.md
# vga_vram_arbiter

Shares one single-port video RAM between the VGA display fetch path and a pixel-write requester (drawing engine or CPU port). Display reads have absolute priority; queued writes drain into every remaining cycle. The block sits between the VGA timing controller (supplying `vid_active`, `vid_x`, `vid_y` in the 25 MHz pixel clock domain) and the VRAM. It returns the colour for each screen pixel with a fixed 2-cycle latency. The framebuffer is 160x120, 3-bit RGB, and each framebuffer pixel covers a 4x4 screen block.

## Interface
Parameters:
- `WR_FIFO_DEPTH`, default 4: write queue depth; must be a power of 2 and ≥2.

Ports:
- `clock` in 1: pixel clock, 25 MHz. Single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `vid_active` in 1: visible-region flag from the timing controller.
- `vid_x` in 10: zero-based screen column, 0..639. Valid only when `vid_active` = 1.
- `vid_y` in 9: zero-based screen row, 0..479. Valid only when `vid_active` = 1.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accepted this cycle when both `wr_valid` and `wr_ready` are 1.
- `wr_x` in 8: framebuffer column.
- `wr_y` in 7: framebuffer row.
- `wr_rgb` in 3: write colour.
- `mem_addr` out 15: VRAM address.
- `mem_we` out 1: VRAM write enable.
- `mem_wdata` out 3: VRAM write data.
- `mem_rdata` in 3: VRAM read data. Valid in the cycle after the address is presented (synchronous RAM).
- `oRGB` out 3: pixel colour, delayed 2 cycles from `vid_*`.

## Operation
- **Address rule:** addr = y*160 + x, computed as (y<<7)+(y<<5)+x in 15 bits. Maximum address is 19199.
- **Display read slot:** a cycle with `vid_active`=1 and `vid_x[1:0]`=0.
  - `mem_we`=0.
  - `mem_addr` = address of (`vid_y`>>2, `vid_x`>>2).
- **Write slot:** any non-display cycle with the FIFO non-empty.
  - `mem_we`=1.
  - `mem_addr`/`mem_wdata` are taken from the FIFO head.
  - The FIFO pops at the closing edge.
- **Out-of-range FIFO head** (x≥160 or y≥120): popped in its slot, `mem_we`=0, the entry is discarded.
- **Idle cycle:** `mem_we`=0, `mem_addr` holds its last value.
- **Write path:**
  - `wr_ready` = FIFO not full.
  - A push occurs on `wr_valid & wr_ready`.
  - A push and a pop in the same cycle are both performed. The count is unchanged.
  - When the FIFO is full, `wr_ready`=0 even if a pop happens that cycle.
- **Pixel pipeline:**
  - `pix_reg` loads `mem_rdata` at the end of the cycle following each display read slot.
  - `active_d1`/`active_d2` delay `vid_active` by 2 cycles.
  - `oRGB` = `active_d2` ? `pix_reg` : 0.
  - `oRGB` is driven only from registers.
- **Arbitration:** fixed. Display always wins the port and is never stalled. Writes cannot starve: at least 3 of every 4 active cycles, plus all blanking cycles, are write slots.

## Timing
- **Display latency:** a display slot at cycle t presents the address in t. `mem_rdata` is valid in t+1. `pix_reg` updates at the t+1→t+2 edge. The same colour appears on `oRGB` for cycles t+2..t+5.
- **Write latency:** an accepted write reaches `mem_we` no earlier than the cycle after acceptance (FIFO registered, no bypass).
- **Reset (`reset`=0), asynchronous:**
  - FIFO is emptied (pointers and count = 0).
  - `pix_reg`, `active_d1`, `active_d2` = 0.
  - `oRGB` = 0.
  - `mem_we` forced to 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `wr_ready` = 0 while reset is asserted, and 1 from the first cycle after release.
- **Reset mid-operation:** queued writes are lost. No partial write is issued.
- **`vid_active` falling while a read is in flight:** `pix_reg` still loads, but `oRGB` shows 0 because `active_d2`=0.

## Configuration
- `VRAM_ARB_BLANK_ONLY_EN` defined: write slots are granted only when `vid_active`=0 (tear-free updates). During active video, writes queue and `wr_ready` falls once the FIFO is full.
- Undefined: write slots include the free active cycles (`vid_x[1:0]`≠0), as described above.

## Structure
- Package `vga_pkg`:
  - `FB_W`=160, `FB_H`=120, `SCALE_SHIFT`=2.
  - `ADDR_W`=15, `RGB_W`=3.
  - Write-entry struct {x[7:0], y[6:0], rgb[2:0]}.
- Sub-module `vram_wr_fifo`: synchronous FIFO parameterised by depth and entry width, with `full`/`empty` flags and async active-low reset.
- Arbitration and the pixel pipeline live in the top module.

## Test plan
- **Reset:** hold `reset`=0 with `wr_valid`=1 and `vid_active`=1 → `oRGB`=0, `mem_we`=0, `wr_ready`=0. One cycle after release → `wr_ready`=1.
- **Display fetch:** preload VRAM addr 161 with 3'b101. Drive `vid_active`=1, `vid_y`=4, `vid_x`=4..7 → `mem_addr`=161 with `mem_we`=0 in the `vid_x`=4 cycle, and `oRGB`=3'b101 for exactly 4 cycles starting 2 cycles later.
- **Write during active video (macro undefined):** push (x=10, y=2, rgb=3'b011) while `vid_x`=1 → `mem_we`=1, `mem_addr`=330, `mem_wdata`=3'b011 in the next non-display cycle. No `mem_we` in any `vid_x[1:0]`=0 cycle.
- **Backpressure:** with `VRAM_ARB_BLANK_ONLY_EN` defined and `vid_active`=1, push 4 writes → `wr_ready`=0 after the 4th. After `vid_active` drops, the 4 writes issue on 4 consecutive cycles and `wr_ready` returns to 1.
- **Out of range:** push (x=200, y=5) then (x=0, y=0, rgb=3'b111) → the first entry produces no `mem_we`. The second writes addr 0 one slot later.
- **Async reset with 3 queued writes:** → no further `mem_we`, FIFO empty, `oRGB`=0 immediately.
